mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multicycle 32-bit multiply/divide execution unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU, which the single-cycle ALU cannot complete in one cycle, and writes the 64-bit result into architectural HI/LO registers. It sits beside the ALU in the execute stage. Control logic launches an operation with a one-cycle start pulse and stalls on Busy until Done.

## Interface
- No parameters; data width fixed at 32 bits.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  launch request; sampled only in IDLE.
- MDOperation  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  32  multiplicand or dividend (rs).
- B  input  32  multiplier or divisor (rt).
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- DivByZero  output  1  valid with Done; high when a DIV or DIVU had B == 0.
- HI  output  32  upper product word, or remainder.
- LO  output  32  lower product word, or quotient.

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE: on Start=1, latch MDOperation, latch the sign flags of A and B, and latch the operand magnitudes. Magnitudes are absolute values for signed ops and raw values for unsigned ops. Clear the 5-bit iteration counter and go to RUN.
  - RUN: perform one radix-2 step per cycle. When the counter equals 31, go to FIX; otherwise increment the counter.
    - Multiply step: shift-add, 64-bit accumulator.
    - Divide step: restoring shift-subtract, 32-bit remainder and quotient.
  - FIX: apply sign correction, write HI/LO, pulse Done for one cycle, return to IDLE.
- Signed multiply: negate the 64-bit product when sign(A) xor sign(B).
- Signed divide:
  - Quotient is negated when sign(A) xor sign(B).
  - Remainder takes the sign of A.
  - Results satisfy A = B*LO + HI and truncate toward zero.
- Division by zero (B == 0, either divide op):
  - Takes full latency.
  - HI = A unchanged, LO = 0xFFFFFFFF, DivByZero = 1 with Done.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, DivByZero = 0.
- MULT/MULTU never assert DivByZero.
- Operand independence: A, B and MDOperation are sampled only at launch, so changes during RUN/FIX have no effect.
- Start while Busy=1 is ignored and is not queued.
- HI/LO hold their last value until the next FIX. They are not modified during RUN.
- DivByZero holds its value until the next FIX.

## Timing
- Launch edge is E0 (Start=1 in IDLE).
- Busy = (state != IDLE). It rises after E0 and falls after E33 (33 cycles high).
- RUN occupies edges E1–E32; the FIX update happens at E33.
- Done, HI, LO and DivByZero are valid in the cycle after E33. Fixed latency is 34 cycles from the Start cycle.
- Back-to-back: Start may be asserted in the same cycle Done is high. That cycle is IDLE, so the next launch occurs at that edge with no bubble.
- Reset (reset=0, any time including mid-operation):
  - State goes to IDLE; Busy = 0, Done = 0, DivByZero = 0.
  - HI = 0, LO = 0; counter and datapath registers are cleared.
  - The aborted operation produces no Done.
- Start is ignored while reset=0. After reset deasserts, the first edge with Start=1 launches.

## Test plan
- MULT, A=0xFFFFFFFD (−3), B=5 -> Done at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFF1, DivByZero=0, Busy high for exactly 33 cycles.
- MULTU, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MULT with the same operands -> HI=0, LO=1.
- DIV, A=0xFFFFFFF9 (−7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU, A=100, B=0 -> Done at cycle 34, DivByZero=1, HI=0x00000064, LO=0xFFFFFFFF.
- DIVU 100/7 (expect LO=14, HI=2) with these disturbances:
  - Start pulsed again and A/B changed mid-RUN -> no effect.
  - New Start in the Done cycle -> second operation launches immediately and completes 34 cycles later.
  - reset=0 at cycle 10 of a further op -> HI=LO=0, Busy=0, no Done.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multicycle 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One radix-2 step per cycle over 32 RUN cycles, then a sign-fixup cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOperation,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state_reg;
  logic [1:0]  op_reg;
  logic        sign_a_reg;
  logic        sign_b_reg;
  logic        b_zero_reg;
  logic [31:0] opnd_reg;
  logic [63:0] acc_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        done_reg;
  logic        dbz_reg;

  // Launch-side operand conditioning
  logic        is_signed;
  logic        sign_a_next;
  logic        sign_b_next;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  always_comb begin
    is_signed   = ~MDOperation[0];
    sign_a_next = is_signed & A[31];
    sign_b_next = is_signed & B[31];
    mag_a       = sign_a_next ? (32'd0 - A) : A;
    mag_b       = sign_b_next ? (32'd0 - B) : B;
  end

  // acc_reg holds the product for multiply, and {remainder, quotient/dividend} for divide
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] rem_sub;
  logic [63:0] step_next;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    div_shift = {acc_reg[63:32], acc_reg[31]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    // When the subtraction is taken the true difference is below the divisor, so 32 bits suffice
    rem_sub   = div_shift[31:0] - opnd_reg;
    if (op_reg[1])
      step_next = {(div_ge ? rem_sub : div_shift[31:0]), acc_reg[30:0], div_ge};
    else
      step_next = {mul_sum, acc_reg[31:1]};
  end

  // Sign correction applied in FIX
  logic        neg_res;
  logic [63:0] mul_res;
  logic [31:0] rem_mag;
  logic [31:0] quo_mag;
  logic [31:0] hi_fix;
  logic [31:0] lo_fix;

  always_comb begin
    neg_res = sign_a_reg ^ sign_b_reg;
    mul_res = neg_res ? (64'd0 - acc_reg) : acc_reg;
    rem_mag = acc_reg[63:32];
    quo_mag = acc_reg[31:0];
    if (op_reg[1]) begin
      hi_fix = sign_a_reg ? (32'd0 - rem_mag) : rem_mag;
      if (b_zero_reg)
        lo_fix = 32'hFFFF_FFFF;
      else
        lo_fix = neg_res ? (32'd0 - quo_mag) : quo_mag;
    end else begin
      hi_fix = mul_res[63:32];
      lo_fix = mul_res[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      op_reg     <= 2'd0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      b_zero_reg <= 1'b0;
      opnd_reg   <= 32'd0;
      acc_reg    <= 64'd0;
      cnt_reg    <= 5'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            op_reg     <= MDOperation;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            b_zero_reg <= (B == 32'd0);
            opnd_reg   <= MDOperation[1] ? mag_b : mag_a;
            acc_reg    <= {32'd0, (MDOperation[1] ? mag_a : mag_b)};
            cnt_reg    <= 5'd0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          acc_reg <= step_next;
          if (cnt_reg == 5'd31)
            state_reg <= FIX;
          else
            cnt_reg <= cnt_reg + 5'd1;
        end
        FIX: begin
          hi_reg    <= hi_fix;
          lo_reg    <= lo_fix;
          dbz_reg   <= op_reg[1] & b_zero_reg;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Busy      = (state_reg != IDLE);
  assign Done      = done_reg;
  assign DivByZero = dbz_reg;
  assign HI        = hi_reg;
  assign LO        = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MDOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .MDOperation(MDOperation),
    .A          (A),
    .B          (B),
    .Busy       (Busy),
    .Done       (Done),
    .DivByZero  (DivByZero),
    .HI         (HI),
    .LO         (LO)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {DivByZero, HI, LO} from plain 64-bit arithmetic
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        p = sa * sb;
        return {1'b0, p};
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Called one time unit after an edge; returns in the Done cycle so a following call launches back-to-back
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] exp;
    int cyc;
    int busy_cnt;
    exp = model(op, a, b);
    Start = 1'b1; MDOperation = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom; MDOperation = 2'($urandom);
    cyc = 1;
    busy_cnt = 0;
    while (Done !== 1'b1 && cyc < 40) begin
      if (Busy === 1'b1) busy_cnt++;
      if (cyc == 20) begin
        check("hold_hi", {32'd0, HI}, {32'd0, prev_hi});
        check("hold_lo", {32'd0, LO}, {32'd0, prev_lo});
      end
      Start = (cyc == 10);
      @(posedge clk); #1;
      cyc++;
    end
    Start = 1'b0;
    check("latency", 64'(cyc), 64'd34);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("done", {63'd0, Done}, 64'd1);
    check("busy_in_done", {63'd0, Busy}, 64'd0);
    check("hi", {32'd0, HI}, {32'd0, exp[63:32]});
    check("lo", {32'd0, LO}, {32'd0, exp[31:0]});
    check("divbyzero", {63'd0, DivByZero}, {63'd0, exp[64]});
    prev_hi = exp[63:32];
    prev_lo = exp[31:0];
    $display("op=%0d A=%h B=%h -> HI=%h LO=%h DivByZero=%0b latency=%0d", op, a, b, HI, LO, DivByZero, cyc);
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check("idle_done", {63'd0, Done}, 64'd0);
    check("idle_busy", {63'd0, Busy}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          done_seen;

    reset = 1'b0; Start = 1'b0; MDOperation = 2'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_dbz", {63'd0, DivByZero}, 64'd0);
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    Start = 1'b1; A = 32'd5; B = 32'd3;
    @(posedge clk); #1;
    check("start_in_reset", {63'd0, Busy}, 64'd0);
    Start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b11, 32'd100, 32'd0);
    do_op(2'b11, 32'd100, 32'd7);
    do_op(2'b11, 32'd100, 32'd7);
    idle_check();

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'd0 - $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb);
    end
    idle_check();

    // Abort an operation with reset partway through RUN
    do_op(2'b10, 32'hFFFF_FF00, 32'd0);
    Start = 1'b1; MDOperation = 2'b11; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, Busy}, 64'd0);
    check("abort_done", {63'd0, Done}, 64'd0);
    check("abort_dbz", {63'd0, DivByZero}, 64'd0);
    check("abort_hi", {32'd0, HI}, 64'd0);
    check("abort_lo", {32'd0, LO}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (Done === 1'b1) done_seen++;
    end
    check("no_done_after_abort", 64'(done_seen), 64'd0);
    check("abort_idle_busy", {63'd0, Busy}, 64'd0);
    do_op(2'b11, 32'd100, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
